// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] IFU_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE   = 2'd0,
    IFU_FETCH  = 2'd1,
    IFU_HALTED = 2'd2
  } ifu_state_e;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifu_entry_t;

  localparam int unsigned ENTRY_W = $bits(ifu_entry_t);

  // Word-align a fetch address by clearing the two low bits.
  function automatic logic [XLEN-1:0] ifu_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush, occupancy count, full and empty flags.
// Simultaneous push and pop on a full FIFO is accepted.
module ifu_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && (!o_full || w_pop) && !i_flush;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The producer must respect credits: a lone push into a full queue is a bug.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush) begin
      a_no_overflow: assert (!(i_push && o_full && !w_pop))
        else $error("ifu_fifo: push into full queue");
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers responses with their PCs and presents them
// to IF/ID. Redirects flush the buffer and drop stale responses; halt
// stops fetching permanently until reset.
// Optional macro IFU_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = IFU_RESET_PC,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [63:0] now_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
  output logic [63:0] perf_flush_cnt
`endif
);

  localparam int unsigned BUF_CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_CW = $clog2(MAX_OUTSTANDING + 1);

  ifu_state_e        r_state;
  ifu_state_e        w_state_next;
  logic [63:0]       r_pc;
  logic [OUT_CW-1:0] r_drop_cnt;
  ifu_entry_t        r_last;

  logic              w_req_valid;
  logic              w_halt_take;
  logic              w_redirect_take;
  logic              w_flush;
  logic              w_credit;
  logic              w_fire;
  logic              w_rsp;
  logic              w_rsp_drop;
  logic              w_push;
  logic              w_pop;
  logic [OUT_CW-1:0] w_out_cnt;
  logic [OUT_CW-1:0] w_out_next;
  logic [BUF_CW-1:0] w_buf_cnt;
  logic              w_buf_empty;
  logic              w_buf_full;
  logic              w_tag_empty;
  logic              w_tag_full;
  logic [63:0]       w_tag_pc;
  ifu_entry_t        w_push_entry;
  ifu_entry_t        w_head;
  logic              w_unused_ok;

  // Space for every in-flight response is reserved before issuing.
  assign w_credit = ((32'(w_out_cnt) + 32'(w_buf_cnt)) < FIFO_DEPTH) &&
                    (32'(w_out_cnt) < MAX_OUTSTANDING);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IFU_IDLE;
    else            r_state <= w_state_next;
  end

  // Next state and per-cycle control; halt beats redirect in FETCH.
  always_comb begin
    w_state_next    = r_state;
    w_req_valid     = 1'b0;
    w_halt_take     = 1'b0;
    w_redirect_take = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        w_state_next    = IFU_FETCH;
        w_redirect_take = redirect_valid;
      end
      IFU_FETCH: begin
        if (halt) begin
          w_state_next = IFU_HALTED;
          w_halt_take  = 1'b1;
        end else if (redirect_valid) begin
          w_redirect_take = 1'b1;
        end else begin
          w_req_valid = w_credit;
        end
      end
      IFU_HALTED: begin
        w_state_next = IFU_HALTED;
      end
      default: begin
        w_state_next = IFU_IDLE;
      end
    endcase
  end

  assign w_flush      = w_halt_take || w_redirect_take;
  assign w_fire       = w_req_valid && imem_req_ready;
  assign w_rsp        = imem_rsp_valid && !w_tag_empty;
  assign w_rsp_drop   = (r_drop_cnt != '0) || (r_state == IFU_HALTED);
  assign w_push       = w_rsp && !w_rsp_drop && !w_flush;
  assign w_pop        = out_valid && out_ready;
  assign w_out_next   = w_out_cnt + OUT_CW'(w_fire) - OUT_CW'(w_rsp);
  assign w_push_entry = '{pc: w_tag_pc, instr: imem_rsp_data};
  assign w_unused_ok  = ^{w_tag_full, w_buf_full};

  // PC of every accepted request, consumed in order by responses; its
  // occupancy is the outstanding-request count and it is never flushed.
  ifu_fifo #(
    .WIDTH (64),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_flush (1'b0),
    .i_push  (w_fire),
    .i_data  (r_pc),
    .i_pop   (w_rsp),
    .o_data  (w_tag_pc),
    .o_count (w_out_cnt),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  // Instruction buffer feeding IF/ID.
  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf_q (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_buf_cnt),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  // PC, stale-response drop count and last-presented entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
      r_last     <= '{pc: 64'h0, instr: IFU_NOP};
    end else begin
      if (w_redirect_take) r_pc <= ifu_align(redirect_pc);
      else if (w_fire)     r_pc <= r_pc + 64'd4;

      if (w_flush)                          r_drop_cnt <= w_out_next;
      else if (w_rsp && r_drop_cnt != '0)   r_drop_cnt <= r_drop_cnt - OUT_CW'(1);

      if (!w_buf_empty) r_last <= w_head;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = !w_buf_empty;
  assign instruction    = out_valid ? w_head.instr : r_last.instr;
  assign now_pc         = out_valid ? w_head.pc    : r_last.pc;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_stall;
  logic [63:0] r_perf_flush;

  // Saturating event counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_fire && r_perf_fetch != '1)                    r_perf_fetch <= r_perf_fetch + 64'd1;
      if (out_valid && !out_ready && r_perf_stall != '1)   r_perf_stall <= r_perf_stall + 64'd1;
      if (w_redirect_take && r_perf_flush != '1)           r_perf_flush <= r_perf_flush + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule
